nf10_axi_lite_master: RTL and testbench
=======================================

Name: nf10_axi_lite_master

Overview:
- AXI4-Lite initiator: accepts one register read or write command on a simple valid/ready command port and issues it as a single AXI4-Lite transaction on the M_AXI channels.
- Returns read data and response code on a valid/ready response port.
- Drives slaves such as the timestamp and register-file peripherals from in-fabric logic, for self-test and hardware-driven configuration.
- Includes a watchdog so that a dead slave cannot hang the command path.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width of CMD_ADDR and M_AXI_AWADDR/ARADDR
- C_M_AXI_DATA_WIDTH, 32, data width; strobe width is C_M_AXI_DATA_WIDTH/8
- C_TIMEOUT_CYCLES, 1024, cycles allowed per outstanding transaction before abort; must be ≥2

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  synchronous active-low reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  command accepted this cycle when high with CMD_VALID
- CMD_RNW  in  1  1=read, 0=write
- CMD_ADDR  in  ADDR_WIDTH  target byte address
- CMD_WDATA  in  DATA_WIDTH  write data (ignored for reads)
- CMD_WSTRB  in  DATA_WIDTH/8  write byte strobes
- RSP_VALID  out  1  response present
- RSP_READY  in  1  response consumed
- RSP_RDATA  out  DATA_WIDTH  read data; 0 for writes and timeouts
- RSP_RESP  out  2  AXI BRESP/RRESP; 2'b10 on timeout
- RSP_TIMEOUT  out  1  transaction aborted by watchdog
- M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY  out  per AXI4-Lite  master-driven signals
- M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID  in  per AXI4-Lite  slave-driven signals

Behaviour:
- **Reset** (M_AXI_ARESETN=0 at a rising edge): state IDLE, all VALID/READY outputs 0, address/data/strobe outputs 0, RSP_* 0, watchdog 0. Reset mid-transaction drops everything with no response; CMD_READY is 0 during reset.
- **Outputs:** all registered. CMD_READY = (state==IDLE).
- **IDLE:** on CMD_VALID&&CMD_READY, latch address, data and strobe.
  - CMD_RNW=1 → RD_ADDR.
  - CMD_RNW=0 → WR_ADDR_DATA.
  - Matching VALID signals rise in the next cycle.
- **WR_ADDR_DATA:**
  - AWVALID and WVALID start high; each drops on the cycle after its own handshake. AW and W are tracked with independent done flags, and either order or simultaneous completion is legal.
  - Address, data and strobe are held stable while the matching VALID is high.
  - When both are done → WR_RESP, with BREADY=1.
- **WR_RESP:** on BVALID&&BREADY, capture BRESP, drop BREADY → RESP.
- **RD_ADDR:** ARVALID=1 until ARREADY. Then ARVALID=0, RREADY=1 → RD_DATA.
- **RD_DATA:** on RVALID&&RREADY, capture RDATA/RRESP, drop RREADY → RESP.
- **RESP:** RSP_VALID=1 with stable fields until RSP_READY. Then RSP_VALID=0 → IDLE. The next command is accepted no earlier than the following cycle.
- **Minimum latency** with a zero-wait slave: command accepted at cycle 0, AW/W/AR valid at cycle 1, BREADY/RREADY at cycle 2, RSP_VALID at cycle 3. Both reads and writes then complete in 4 cycles including the RSP_READY cycle.
- **Watchdog:**
  - Counter clears on command accept and increments each cycle in WR_ADDR_DATA, WR_RESP, RD_ADDR or RD_DATA.
  - When it reaches C_TIMEOUT_CYCLES-1 without completing, the next edge forces all M_AXI VALID/READY outputs to 0 and enters RESP with RSP_TIMEOUT=1, RSP_RESP=2'b10 and RSP_RDATA=0.
  - This deliberately breaks AXI VALID stability for recovery only.
  - A completion handshake in the same cycle as expiry wins, giving a normal response.
- **Late slave responses:** BVALID/RVALID arriving while BREADY/RREADY are 0 are ignored.
- **Read data for writes:** RSP_RDATA=0.
- **Slave error codes:** SLVERR and DECERR from the slave are passed through with RSP_TIMEOUT=0.
- **Outstanding transactions:** only one at a time; no pipelining.

Test Plan:
1. Write addr 0x78a00004, data 0xDEADBEEF, strb 0xF, slave ready immediately, BRESP=0 → AWVALID/WVALID at cycle 1 only, BREADY at cycle 2, RSP_VALID at cycle 3 with RSP_RESP=0, RSP_TIMEOUT=0.
2. Write with AWREADY delayed 3 cycles and WREADY immediate, then the reverse → WVALID drops after its own handshake, AWVALID is held with a stable address, BREADY only after both, exactly one response.
3. Read addr 0x78a00008, RVALID 5 cycles after ARREADY, RDATA=0x12345678, RRESP=0 → RSP_RDATA=0x12345678. Hold RSP_READY=0 for 4 cycles → RSP fields stable and CMD_READY=0 throughout.
4. Read to a silent slave (ARREADY never asserted), C_TIMEOUT_CYCLES=16 → ARVALID drops after 16 cycles, RSP_TIMEOUT=1, RSP_RESP=2'b10, RSP_RDATA=0, CMD_READY returns after RSP_READY.
5. Write returns BRESP=2'b11 → RSP_RESP=2'b11, RSP_TIMEOUT=0.
6. Assert M_AXI_ARESETN=0 for 1 cycle while in RD_DATA → all VALID/READY outputs 0 on the next cycle, no RSP_VALID, and a new command is accepted after reset release.

Source files
------------

// File: rtl/nf10_axi_lite_master_if.sv
// ---------------------------------------------------------------------------
// nf10_axi_lite_master_if
// Bundles the command port, the response port and the AXI4-Lite master
// channels of nf10_axi_lite_master.
//   modport master : the initiator side (drives CMD_READY, RSP_*, M_AXI
//                    master signals; receives CMD_*, RSP_READY and the
//                    slave-driven M_AXI signals)
//   modport slave  : the environment side (command source, response sink
//                    and AXI4-Lite slave), the exact mirror of master
// Parameters ADDR_W / DATA_W must match the initiator's address/data widths.
// ---------------------------------------------------------------------------
interface nf10_axi_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // command port
  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_RNW;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [DATA_W-1:0] CMD_WDATA;
  logic [STRB_W-1:0] CMD_WSTRB;

  // response port
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [DATA_W-1:0] RSP_RDATA;
  logic [1:0]        RSP_RESP;
  logic              RSP_TIMEOUT;

  // AXI4-Lite write address / data / response
  logic [ADDR_W-1:0] M_AXI_AWADDR;
  logic              M_AXI_AWVALID;
  logic              M_AXI_AWREADY;
  logic [DATA_W-1:0] M_AXI_WDATA;
  logic [STRB_W-1:0] M_AXI_WSTRB;
  logic              M_AXI_WVALID;
  logic              M_AXI_WREADY;
  logic [1:0]        M_AXI_BRESP;
  logic              M_AXI_BVALID;
  logic              M_AXI_BREADY;

  // AXI4-Lite read address / data
  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;
  logic [DATA_W-1:0] M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;
  logic              M_AXI_RVALID;
  logic              M_AXI_RREADY;

  modport master (
    input  CMD_VALID, CMD_RNW, CMD_ADDR, CMD_WDATA, CMD_WSTRB,
    output CMD_READY,
    output RSP_VALID, RSP_RDATA, RSP_RESP, RSP_TIMEOUT,
    input  RSP_READY,
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    output CMD_VALID, CMD_RNW, CMD_ADDR, CMD_WDATA, CMD_WSTRB,
    input  CMD_READY,
    input  RSP_VALID, RSP_RDATA, RSP_RESP, RSP_TIMEOUT,
    output RSP_READY,
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/nf10_axi_lite_master.sv
// ---------------------------------------------------------------------------
// nf10_axi_lite_master
// Single-outstanding AXI4-Lite initiator. A read or write command taken on
// the CMD valid/ready port becomes one AXI4-Lite transaction; the result is
// returned on the RSP valid/ready port. A watchdog aborts a transaction the
// slave never finishes and reports it as SLVERR with RSP_TIMEOUT set.
// Ports:
//   M_AXI_ACLK     clock
//   M_AXI_ARESETN  synchronous active-low reset
//   bus            nf10_axi_lite_master_if.master (CMD_*, RSP_*, M_AXI_*)
// All outputs are registered.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// S_IDLE         | CMD_READY high, waiting for a command
// S_WR_ADDR_DATA | AWVALID/WVALID outstanding, each drops after its handshake
// S_WR_RESP      | BREADY high, waiting for BVALID
// S_RD_ADDR      | ARVALID high, waiting for ARREADY
// S_RD_DATA      | RREADY high, waiting for RVALID
// S_RESP         | RSP_VALID high with stable fields until RSP_READY
// ---------------------------------------------------------------------------
module nf10_axi_lite_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  nf10_axi_lite_master_if.master        bus
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
  localparam int WDOG_W = $clog2(C_TIMEOUT_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(C_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RESP
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;

  logic                            r_cmd_ready;
  logic                            r_awvalid;
  logic                            r_wvalid;
  logic                            r_bready;
  logic                            r_arvalid;
  logic                            r_rready;
  logic                            r_aw_done;
  logic                            r_w_done;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]               r_wstrb;
  logic                            r_rsp_valid;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]                      r_rsp_resp;
  logic                            r_rsp_timeout;
  logic [WDOG_W-1:0]               r_wdog;

  logic                            w_cmd_fire;
  logic                            w_aw_hs;
  logic                            w_w_hs;
  logic                            w_ar_hs;
  logic                            w_b_hs;
  logic                            w_r_hs;
  logic                            w_active;
  logic                            w_expire;
  logic                            w_aw_done_nxt;
  logic                            w_w_done_nxt;

  logic                            w_nxt_cmd_ready;
  logic                            w_nxt_awvalid;
  logic                            w_nxt_wvalid;
  logic                            w_nxt_bready;
  logic                            w_nxt_arvalid;
  logic                            w_nxt_rready;
  logic                            w_nxt_rsp_valid;
  logic [C_M_AXI_DATA_WIDTH-1:0]   w_nxt_rsp_rdata;
  logic [1:0]                      w_nxt_rsp_resp;
  logic                            w_nxt_rsp_timeout;
  logic [WDOG_W-1:0]               w_nxt_wdog;

  // r_cmd_ready is only ever high in S_IDLE
  assign w_cmd_fire = bus.CMD_VALID && r_cmd_ready;
  assign w_aw_hs    = r_awvalid && bus.M_AXI_AWREADY;
  assign w_w_hs     = r_wvalid  && bus.M_AXI_WREADY;
  assign w_ar_hs    = r_arvalid && bus.M_AXI_ARREADY;
  assign w_b_hs     = r_bready  && bus.M_AXI_BVALID;
  assign w_r_hs     = r_rready  && bus.M_AXI_RVALID;

  assign w_active = (r_state == S_WR_ADDR_DATA) || (r_state == S_WR_RESP) ||
                    (r_state == S_RD_ADDR)      || (r_state == S_RD_DATA);
  assign w_expire = w_active && (r_wdog == WDOG_LAST);

  // done flags include this cycle's handshake so AW/W in either order work
  assign w_aw_done_nxt = (r_state == S_WR_ADDR_DATA) && (r_aw_done || w_aw_hs);
  assign w_w_done_nxt  = (r_state == S_WR_ADDR_DATA) && (r_w_done  || w_w_hs);

  // state register plus the registered copies of every output
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= 2'b00;
      r_rsp_timeout <= 1'b0;
      r_wdog        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= w_nxt_cmd_ready;
      r_awvalid     <= w_nxt_awvalid;
      r_wvalid      <= w_nxt_wvalid;
      r_bready      <= w_nxt_bready;
      r_arvalid     <= w_nxt_arvalid;
      r_rready      <= w_nxt_rready;
      r_aw_done     <= w_aw_done_nxt;
      r_w_done      <= w_w_done_nxt;
      r_rsp_valid   <= w_nxt_rsp_valid;
      r_rsp_rdata   <= w_nxt_rsp_rdata;
      r_rsp_resp    <= w_nxt_rsp_resp;
      r_rsp_timeout <= w_nxt_rsp_timeout;
      r_wdog        <= w_nxt_wdog;
      if (w_cmd_fire) begin
        r_addr  <= bus.CMD_ADDR;
        r_wdata <= bus.CMD_WDATA;
        r_wstrb <= bus.CMD_WSTRB;
      end
    end
  end

  // next-state logic; a completing handshake and expiry both lead to S_RESP,
  // the output logic decides which kind of response is produced
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          w_state_nxt = bus.CMD_RNW ? S_RD_ADDR : S_WR_ADDR_DATA;
        end
      end
      S_WR_ADDR_DATA: begin
        if (w_expire) begin
          w_state_nxt = S_RESP;
        end else if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (w_b_hs || w_expire) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RD_ADDR: begin
        if (w_expire) begin
          w_state_nxt = S_RESP;
        end else if (w_ar_hs) begin
          w_state_nxt = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (w_r_hs || w_expire) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.RSP_READY) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // output logic: next values of the registered outputs, derived from the
  // next state so an expiry drops every VALID/READY on the same edge
  always_comb begin
    w_nxt_cmd_ready   = (w_state_nxt == S_IDLE);
    w_nxt_awvalid     = (w_state_nxt == S_WR_ADDR_DATA) && !w_aw_done_nxt;
    w_nxt_wvalid      = (w_state_nxt == S_WR_ADDR_DATA) && !w_w_done_nxt;
    w_nxt_bready      = (w_state_nxt == S_WR_RESP);
    w_nxt_arvalid     = (w_state_nxt == S_RD_ADDR);
    w_nxt_rready      = (w_state_nxt == S_RD_DATA);
    w_nxt_rsp_valid   = (w_state_nxt == S_RESP);
    w_nxt_rsp_rdata   = r_rsp_rdata;
    w_nxt_rsp_resp    = r_rsp_resp;
    w_nxt_rsp_timeout = r_rsp_timeout;
    w_nxt_wdog        = r_wdog;

    if ((r_state != S_RESP) && (w_state_nxt == S_RESP)) begin
      if (w_b_hs) begin
        w_nxt_rsp_rdata   = '0;
        w_nxt_rsp_resp    = bus.M_AXI_BRESP;
        w_nxt_rsp_timeout = 1'b0;
      end else if (w_r_hs) begin
        w_nxt_rsp_rdata   = bus.M_AXI_RDATA;
        w_nxt_rsp_resp    = bus.M_AXI_RRESP;
        w_nxt_rsp_timeout = 1'b0;
      end else begin
        w_nxt_rsp_rdata   = '0;
        w_nxt_rsp_resp    = 2'b10;
        w_nxt_rsp_timeout = 1'b1;
      end
    end

    if (w_cmd_fire) begin
      w_nxt_wdog = '0;
    end else if (w_active) begin
      w_nxt_wdog = r_wdog + 1'b1;
    end
  end

  assign bus.CMD_READY     = r_cmd_ready;
  assign bus.RSP_VALID     = r_rsp_valid;
  assign bus.RSP_RDATA     = r_rsp_rdata;
  assign bus.RSP_RESP      = r_rsp_resp;
  assign bus.RSP_TIMEOUT   = r_rsp_timeout;
  assign bus.M_AXI_AWADDR  = r_addr;
  assign bus.M_AXI_AWVALID = r_awvalid;
  assign bus.M_AXI_WDATA   = r_wdata;
  assign bus.M_AXI_WSTRB   = r_wstrb;
  assign bus.M_AXI_WVALID  = r_wvalid;
  assign bus.M_AXI_BREADY  = r_bready;
  assign bus.M_AXI_ARADDR  = r_addr;
  assign bus.M_AXI_ARVALID = r_arvalid;
  assign bus.M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_nf10_axi_lite_master.sv
// ---------------------------------------------------------------------------
// tb_nf10_axi_lite_master
// Directed bench for nf10_axi_lite_master with a configurable AXI4-Lite
// slave model. Accepted commands push their hand-computed response into a
// scoreboard queue; an independent monitor pops and compares whenever a
// response is handed over on the RSP port.
// ---------------------------------------------------------------------------
module tb_nf10_axi_lite_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
    int          lat;
    int          acc;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nf10_axi_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  nf10_axi_lite_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_TIMEOUT_CYCLES  (TO)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rstn),
    .bus          (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   n_rsp = 0;
  int   cyc   = 0;
  exp_t sb_q[$];

  // slave model configuration
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0;
  bit          ar_silent = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  int          rsp_hold = 0;

  // bus observation
  int          aw_hi = 0, w_hi = 0, ar_hi = 0, bus_bad = 0;
  logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
  logic [3:0]  exp_wstrb = 4'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- slave model (drives on the falling edge) --------------
  initial begin : aw_slave
    int c = 0;
    bus.M_AXI_AWREADY = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY) begin
        if (c == aw_dly) begin bus.M_AXI_AWREADY = 1'b1; c = 0; end
        else c++;
      end else begin
        bus.M_AXI_AWREADY = 1'b0; c = 0;
      end
    end
  end

  initial begin : w_slave
    int c = 0;
    bus.M_AXI_WREADY = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.M_AXI_WVALID && !bus.M_AXI_WREADY) begin
        if (c == w_dly) begin bus.M_AXI_WREADY = 1'b1; c = 0; end
        else c++;
      end else begin
        bus.M_AXI_WREADY = 1'b0; c = 0;
      end
    end
  end

  initial begin : b_slave
    int c = 0;
    bus.M_AXI_BVALID = 1'b0;
    bus.M_AXI_BRESP  = 2'b00;
    forever begin
      @(negedge clk);
      if (bus.M_AXI_BREADY && !bus.M_AXI_BVALID) begin
        if (c == b_dly) begin
          bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = bresp_cfg; c = 0;
        end else c++;
      end else begin
        bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = 2'b00; c = 0;
      end
    end
  end

  initial begin : ar_slave
    int c = 0;
    bus.M_AXI_ARREADY = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY && !ar_silent) begin
        if (c == ar_dly) begin bus.M_AXI_ARREADY = 1'b1; c = 0; end
        else c++;
      end else begin
        bus.M_AXI_ARREADY = 1'b0; c = 0;
      end
    end
  end

  initial begin : r_slave
    int c = 0;
    bus.M_AXI_RVALID = 1'b0;
    bus.M_AXI_RDATA  = 32'h0;
    bus.M_AXI_RRESP  = 2'b00;
    forever begin
      @(negedge clk);
      if (bus.M_AXI_RREADY && !bus.M_AXI_RVALID) begin
        if (c == r_dly) begin
          bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RDATA = rdata_cfg;
          bus.M_AXI_RRESP  = rresp_cfg; c = 0;
        end else c++;
      end else begin
        bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RDATA = 32'h0;
        bus.M_AXI_RRESP  = 2'b00; c = 0;
      end
    end
  end

  // response consumer: holds RSP_READY low for rsp_hold cycles of RSP_VALID
  initial begin : rsp_sink
    int c = 0;
    bus.RSP_READY = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.RSP_VALID && !bus.RSP_READY) begin
        if (c == rsp_hold) begin bus.RSP_READY = 1'b1; c = 0; end
        else c++;
      end else begin
        bus.RSP_READY = 1'b0; c = 0;
      end
    end
  end

  // ---------------- bus observer ------------------------------------------
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (bus.M_AXI_AWVALID) begin
        aw_hi++;
        if (bus.M_AXI_AWADDR !== exp_addr) bus_bad++;
      end
      if (bus.M_AXI_WVALID) begin
        w_hi++;
        if (bus.M_AXI_WDATA !== exp_wdata || bus.M_AXI_WSTRB !== exp_wstrb) bus_bad++;
      end
      if (bus.M_AXI_ARVALID) begin
        ar_hi++;
        if (bus.M_AXI_ARADDR !== exp_addr) bus_bad++;
      end
      if (bus.M_AXI_BREADY && (bus.M_AXI_AWVALID || bus.M_AXI_WVALID)) bus_bad++;
    end
  end

  // ---------------- response monitor / scoreboard -------------------------
  initial begin : monitor
    bit          in_rsp = 1'b0;
    bit          stable = 1'b1;
    logic [31:0] f_rdata = 32'h0;
    logic [1:0]  f_resp = 2'b00;
    logic        f_to = 1'b0;
    int          f_cyc = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (bus.RSP_VALID) begin
        if (!in_rsp) begin
          in_rsp  = 1'b1;
          stable  = 1'b1;
          f_rdata = bus.RSP_RDATA;
          f_resp  = bus.RSP_RESP;
          f_to    = bus.RSP_TIMEOUT;
          f_cyc   = cyc;
        end else if (bus.RSP_RDATA !== f_rdata || bus.RSP_RESP !== f_resp ||
                     bus.RSP_TIMEOUT !== f_to) begin
          stable = 1'b0;
        end
        if (bus.CMD_READY) stable = 1'b0;
        if (bus.RSP_READY) begin
          n_rsp++;
          in_rsp = 1'b0;
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rsp: got a response, expected none (resp=%0d)", f_resp);
          end else begin
            e = sb_q.pop_front();
            chk("rsp_rdata",   {32'h0, f_rdata}, {32'h0, e.rdata});
            chk("rsp_resp",    {62'h0, f_resp},  {62'h0, e.resp});
            chk("rsp_timeout", {63'h0, f_to},    {63'h0, e.to});
            chk("rsp_stable",  {63'h0, stable},  64'h1);
            if (e.lat >= 0) chk("rsp_latency", 64'(f_cyc - e.acc), 64'(e.lat));
          end
        end
      end else begin
        in_rsp = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic clr_obs();
    aw_hi = 0; w_hi = 0; ar_hi = 0; bus_bad = 0;
  endtask

  task automatic issue(input bit rnw, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] e_rdata,
                       input logic [1:0] e_resp, input bit e_to, input int e_lat,
                       input bit push);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    exp_addr = addr; exp_wdata = wdata; exp_wstrb = wstrb;
    bus.CMD_VALID = 1'b1;
    bus.CMD_RNW   = rnw;
    bus.CMD_ADDR  = addr;
    bus.CMD_WDATA = wdata;
    bus.CMD_WSTRB = wstrb;
    while (!bus.CMD_READY && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.CMD_READY) begin
      n_vec++;
      n_err++;
      $display("FAIL cmd_accept: CMD_READY stayed 0 for %0d cycles, expected 1", n);
    end else if (push) begin
      e.rdata = e_rdata; e.resp = e_resp; e.to = e_to; e.lat = e_lat; e.acc = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL rsp_wait: %0d responses outstanding after %0d cycles, expected 0",
               sb_q.size(), n);
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    int n;
    bus.CMD_VALID = 1'b0;
    bus.CMD_RNW   = 1'b0;
    bus.CMD_ADDR  = 32'h0;
    bus.CMD_WDATA = 32'h0;
    bus.CMD_WSTRB = 4'h0;

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {63'h0, bus.CMD_READY}, 64'h0);
    chk("rst_axi_hs", {59'h0, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                       bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 64'h0);
    chk("rst_rsp", {27'h0, bus.RSP_VALID, bus.RSP_RDATA, bus.RSP_RESP, bus.RSP_TIMEOUT}, 64'h0);
    chk("rst_axi_payload", {bus.M_AXI_AWADDR, bus.M_AXI_WDATA} | {28'h0, bus.M_AXI_WSTRB, bus.M_AXI_ARADDR}, 64'h0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cmd_ready", {63'h0, bus.CMD_READY}, 64'h1);

    // 1: zero-wait write
    clr_obs();
    issue(1'b0, 32'h78a0_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 1'b0, 3, 1'b1);
    wait_done();
    chk("t1_aw_cycles", 64'(aw_hi), 64'd1);
    chk("t1_w_cycles",  64'(w_hi),  64'd1);
    chk("t1_bus_rules", 64'(bus_bad), 64'd0);

    // 2a: AWREADY late, WREADY immediate
    clr_obs();
    aw_dly = 3;
    issue(1'b0, 32'h78a0_0010, 32'h0102_0304, 4'h3, 32'h0, 2'b00, 1'b0, 6, 1'b1);
    wait_done();
    chk("t2a_aw_cycles", 64'(aw_hi), 64'd4);
    chk("t2a_w_cycles",  64'(w_hi),  64'd1);
    chk("t2a_bus_rules", 64'(bus_bad), 64'd0);

    // 2b: WREADY late, AWREADY immediate
    clr_obs();
    aw_dly = 0; w_dly = 3;
    issue(1'b0, 32'h78a0_0014, 32'hA0B1_C2D3, 4'hC, 32'h0, 2'b00, 1'b0, 6, 1'b1);
    wait_done();
    w_dly = 0;
    chk("t2b_aw_cycles", 64'(aw_hi), 64'd1);
    chk("t2b_w_cycles",  64'(w_hi),  64'd4);
    chk("t2b_bus_rules", 64'(bus_bad), 64'd0);
    chk("t2_rsp_count",  64'(n_rsp), 64'd3);

    // 3: read, slow RVALID, consumer stalls the response
    clr_obs();
    r_dly = 4; rdata_cfg = 32'h1234_5678; rsp_hold = 4;
    issue(1'b1, 32'h78a0_0008, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 1'b0, 7, 1'b1);
    wait_done();
    rsp_hold = 0; r_dly = 0;
    chk("t3_ar_cycles",  64'(ar_hi), 64'd1);
    chk("t3_bus_rules",  64'(bus_bad), 64'd0);

    // 4: silent slave, watchdog expiry
    clr_obs();
    ar_silent = 1'b1;
    issue(1'b1, 32'h78a0_000C, 32'h0, 4'h0, 32'h0, 2'b10, 1'b1, 17, 1'b1);
    wait_done();
    ar_silent = 1'b0;
    chk("t4_ar_cycles", 64'(ar_hi), 64'd16);
    chk("t4_cmd_ready", {63'h0, bus.CMD_READY}, 64'h1);

    // 5: write with DECERR
    bresp_cfg = 2'b11;
    issue(1'b0, 32'h78a0_0020, 32'h5555_AAAA, 4'h1, 32'h0, 2'b11, 1'b0, 3, 1'b1);
    wait_done();
    bresp_cfg = 2'b00;

    // 6: read with SLVERR, data passed through
    rresp_cfg = 2'b10; rdata_cfg = 32'hCAFE_F00D;
    issue(1'b1, 32'h78a0_0024, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b10, 1'b0, 3, 1'b1);
    wait_done();
    rresp_cfg = 2'b00;

    // 7: RVALID handshake in the expiry cycle -> normal response wins
    r_dly = 14; rdata_cfg = 32'hA5A5_0001;
    issue(1'b1, 32'h78a0_0028, 32'h0, 4'h0, 32'hA5A5_0001, 2'b00, 1'b0, 17, 1'b1);
    wait_done();

    // 8: RVALID one cycle too late -> timeout
    r_dly = 15; rdata_cfg = 32'hA5A5_0002;
    issue(1'b1, 32'h78a0_002C, 32'h0, 4'h0, 32'h0, 2'b10, 1'b1, 17, 1'b1);
    wait_done();

    // 9: reset while in RD_DATA drops the transaction
    r_dly = 10; rdata_cfg = 32'h7777_7777;
    issue(1'b1, 32'h78a0_0030, 32'h0, 4'h0, 32'h0, 2'b00, 1'b0, -1, 1'b0);
    n = 0;
    while (!bus.M_AXI_RREADY && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t9_in_rd_data", {63'h0, bus.M_AXI_RREADY}, 64'h1);
    rstn = 1'b0;
    @(negedge clk);
    chk("t9_rst_axi_hs", {59'h0, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                          bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 64'h0);
    chk("t9_rst_rsp_cmd", {62'h0, bus.RSP_VALID, bus.CMD_READY}, 64'h0);
    rstn = 1'b1;
    r_dly = 0; rdata_cfg = 32'h0BAD_C0DE;
    repeat (2) @(negedge clk);
    issue(1'b1, 32'h78a0_0034, 32'h0, 4'h0, 32'h0BAD_C0DE, 2'b00, 1'b0, 3, 1'b1);
    wait_done();
    chk("total_rsp_count", 64'(n_rsp), 64'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

endmodule
